morse_sequencer: RTL and testbench

//  Morse output engine driven by the control unit's morse_in strobe during MRS.
//  - Latches the memory-bus byte and encodes it as a hex-digit Morse character.
//  - Sequences mark/space timing on morse_out using a unit-time counter.
//  - Reports busy, done and dropped-request status back to the control/flags logic.

---
 rtl/morse_sequencer_if.sv | 20 ++
 rtl/morse_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_morse_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/morse_sequencer_if.sv
// Control/memory-bus side of the Morse output engine: request strobe, data byte
// and the status lines reported back to the control/flags logic.
interface morse_sequencer_if;
    logic       morse_in;
    logic [7:0] data_in;
    logic       morse_out;
    logic       busy;
    logic       done;
    logic       dropped;

    modport master (
        output morse_in, data_in,
        input  morse_out, busy, done, dropped
    );

    modport slave (
        input  morse_in, data_in,
        output morse_out, busy, done, dropped
    );
endinterface

// File: rtl/morse_sequencer.sv
// Morse key sequencer: encodes a latched hex nibble as a Morse character and times
// mark/space on morse_out. Define MORSE_BYTE_EN to send high then low nibble.
module morse_sequencer #(
    parameter int DOT_CYCLES = 2
) (
    input logic              clock,
    input logic              bReset,
    morse_sequencer_if.slave bus
);
    localparam int CW = $clog2(3 * DOT_CYCLES);
    localparam logic [CW-1:0] UNIT_LD = CW'(DOT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LD = CW'(3 * DOT_CYCLES - 1);

`ifdef MORSE_BYTE_EN
    localparam int DW = 8;
    typedef enum logic [2:0] {IDLE, MARK, SPACE, TAIL, CHARGAP} state_e;
`else
    localparam int DW = 4;
    typedef enum logic [1:0] {IDLE, MARK, SPACE, TAIL} state_e;
`endif

    // {length[2:0], pattern[4:0]}; pattern is MSB-first from bit 4, 1 = dash
    function automatic logic [7:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = {3'd5, 5'b11111};
            4'h1: enc = {3'd5, 5'b01111};
            4'h2: enc = {3'd5, 5'b00111};
            4'h3: enc = {3'd5, 5'b00011};
            4'h4: enc = {3'd5, 5'b00001};
            4'h5: enc = {3'd5, 5'b00000};
            4'h6: enc = {3'd5, 5'b10000};
            4'h7: enc = {3'd5, 5'b11000};
            4'h8: enc = {3'd5, 5'b11100};
            4'h9: enc = {3'd5, 5'b11110};
            4'hA: enc = {3'd2, 5'b01000};
            4'hB: enc = {3'd4, 5'b10000};
            4'hC: enc = {3'd4, 5'b10100};
            4'hD: enc = {3'd3, 5'b10000};
            4'hE: enc = {3'd1, 5'b00000};
            default: enc = {3'd4, 5'b00100};
        endcase
    endfunction

    function automatic logic [CW-1:0] mark_ld(input logic [3:0] n, input logic [2:0] idx);
        return ((enc(n) & (8'h10 >> idx)) != 8'h00) ? DASH_LD : UNIT_LD;
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      sym_q, sym_d;
    logic [DW-1:0]   data_q, data_d;
    logic            req_q, req_d;
    logic            morse_out_q, morse_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dropped_q, dropped_d;
`ifdef MORSE_BYTE_EN
    logic            second_q, second_d;
`else
    logic            unused_hi;
    assign unused_hi = ^bus.data_in[7:4];
`endif

    logic       edge_w;
    logic [3:0] cur_nib;
    logic [3:0] start_nib;
    logic [7:0] cur_enc;
    logic       last_sym;

    always_comb begin
        edge_w = bus.morse_in & ~req_q;
`ifdef MORSE_BYTE_EN
        cur_nib   = second_q ? data_q[3:0] : data_q[7:4];
        start_nib = bus.data_in[7:4];
        second_d  = second_q;
`else
        cur_nib   = data_q;
        start_nib = bus.data_in[3:0];
`endif
        cur_enc   = enc(cur_nib);
        last_sym  = (sym_q == cur_enc[7:5] - 3'd1);

        state_d   = state_q;
        cnt_d     = cnt_q;
        sym_d     = sym_q;
        data_d    = data_q;
        req_d     = bus.morse_in;
        done_d    = 1'b0;
        dropped_d = edge_w & (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (edge_w) begin
                    data_d  = bus.data_in[DW-1:0];
                    sym_d   = 3'd0;
                    cnt_d   = mark_ld(start_nib, 3'd0);
                    state_d = MARK;
`ifdef MORSE_BYTE_EN
                    second_d = 1'b0;
`endif
                end
            end
            MARK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (last_sym) begin
                    cnt_d   = DASH_LD;
`ifdef MORSE_BYTE_EN
                    state_d = second_q ? TAIL : CHARGAP;
`else
                    state_d = TAIL;
`endif
                end else begin
                    cnt_d   = UNIT_LD;
                    sym_d   = sym_q + 3'd1;
                    state_d = SPACE;
                end
            end
            SPACE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d   = mark_ld(cur_nib, sym_q);
                    state_d = MARK;
                end
            end
            TAIL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef MORSE_BYTE_EN
            CHARGAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    second_d = 1'b1;
                    sym_d    = 3'd0;
                    cnt_d    = mark_ld(data_q[3:0], 3'd0);
                    state_d  = MARK;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        morse_out_d = (state_d == MARK);
        busy_d      = (state_d != IDLE);
    end

    // req_q resets high so a request already asserted at reset release never starts
    always_ff @(posedge clock) begin
        if (bReset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sym_q       <= '0;
            data_q      <= '0;
            req_q       <= 1'b1;
            morse_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dropped_q   <= 1'b0;
`ifdef MORSE_BYTE_EN
            second_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sym_q       <= sym_d;
            data_q      <= data_d;
            req_q       <= req_d;
            morse_out_q <= morse_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dropped_q   <= dropped_d;
`ifdef MORSE_BYTE_EN
            second_q    <= second_d;
`endif
        end
    end

    assign bus.morse_out = morse_out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dropped   = dropped_q;
endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer: DOT_CYCLES=2 and DOT_CYCLES=1 instances share stimulus;
// expected key waveforms are hand-written strings, one char per cycle after the start edge.
module tb_morse_sequencer;
    logic       clock = 1'b0;
    logic       bReset = 1'b1;
    logic       mi = 1'b0;
    logic [7:0] din = 8'h00;
    logic       sel = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    morse_sequencer_if if0 ();
    morse_sequencer_if if1 ();
    assign if0.morse_in = mi;
    assign if0.data_in  = din;
    assign if1.morse_in = mi;
    assign if1.data_in  = din;

    morse_sequencer #(.DOT_CYCLES(2)) dut0 (.clock(clock), .bReset(bReset), .bus(if0));
    morse_sequencer #(.DOT_CYCLES(1)) dut1 (.clock(clock), .bReset(bReset), .bus(if1));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got[3:0], exp[3:0]);
        end
    endtask

    // {morse_out, busy, done, dropped} of the selected instance
    function automatic logic [3:0] outs();
        if (sel) return {if1.morse_out, if1.busy, if1.done, if1.dropped};
        return {if0.morse_out, if0.busy, if0.done, if0.dropped};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [7:0] d);
        mi = 1'b0;
        step();
        step();
        din = d;
        mi  = 1'b1;
    endtask

    // lower_at: cycle where morse_in is dropped; drop_lo: low cycle of a mid-character re-edge
    task automatic run_pattern(input string tag, input string mo, input int lower_at, input int drop_lo);
        logic mb;
        for (int c = 1; c <= mo.len(); c++) begin
            step();
            mb = (mo[c-1] == "1");
            check($sformatf("%s c%0d", tag, c), {28'd0, outs()},
                  {28'd0, mb, 1'b1, 1'b0, (c == drop_lo + 2)});
            if (c == 1) din = ~din;
            if (c == lower_at) mi = 1'b0;
            if (c == drop_lo) mi = 1'b0;
            if (c == drop_lo + 1) mi = 1'b1;
        end
        step();
        check($sformatf("%s done", tag), {28'd0, outs()}, 32'b0010);
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            step();
            check($sformatf("%s idle%0d", tag, c), {28'd0, outs()}, 32'd0);
        end
    endtask

    initial begin
        step();
        step();
        sel = 1'b0;
        check("rst0", {28'd0, outs()}, 32'd0);
        sel = 1'b1;
        check("rst1", {28'd0, outs()}, 32'd0);
        bReset = 1'b0;
        step();

`ifdef MORSE_BYTE_EN
        sel = 1'b1;
        start(8'h5E);
        run_pattern("t5", "1010101010001000", 0, -10);
        idle_check("t5", 3);
`else
        sel = 1'b0;
        start(8'h0E);
        run_pattern("t1", "11000000", 0, -10);
        idle_check("t1", 6);

        start(8'h0A);
        run_pattern("t2", "1100111111000000", 0, -10);
        idle_check("t2", 2);

        start(8'h0A);
        run_pattern("t3", "1100111111000000", 0, 3);
        idle_check("t3", 2);

        // re-request presented in the done cycle is accepted
        start(8'h0E);
        run_pattern("t7a", "11000000", 1, -10);
        din = 8'h0D;
        mi  = 1'b1;
        run_pattern("t7b", "11111100110011000000", 0, -10);

        start(8'h00);
        step();
        step();
        step();
        check("t4 dash", {28'd0, outs()}, 32'b1100);
        bReset = 1'b1;
        step();
        check("t4 rst", {28'd0, outs()}, 32'd0);
        bReset = 1'b0;
        idle_check("t4 held", 5);
        start(8'h0D);
        run_pattern("t4 D", "11111100110011000000", 0, -10);

        start(8'h5E);
        run_pattern("t6", "11000000", 0, -10);
        idle_check("t6", 2);

        sel = 1'b1;
        start(8'h0A);
        run_pattern("t8 dot1", "10111000", 0, -10);
        idle_check("t8", 2);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
